// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single mem-style port.
// Each requester's exec pulse is latched into a holding register; one
// transaction at a time is forwarded to mem and its completion (or a
// watchdog timeout) is routed back to the owning requester.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          m0_i_exec,
  input  logic [AW-1:0] m0_i_addr,
  input  logic [DW-1:0] m0_i_data,
  input  logic [2:0]    m0_i_sel,
  input  logic          m0_i_we,
  output logic [DW-1:0] m0_o_data,
  output logic          m0_o_fin,
  output logic          m0_o_err,
  output logic          m0_o_busy,
  input  logic          m1_i_exec,
  input  logic [AW-1:0] m1_i_addr,
  input  logic [DW-1:0] m1_i_data,
  input  logic [2:0]    m1_i_sel,
  input  logic          m1_i_we,
  output logic [DW-1:0] m1_o_data,
  output logic          m1_o_fin,
  output logic          m1_o_err,
  output logic          m1_o_busy,
  output logic          o_mem_exec,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_data,
  output logic [2:0]    o_mem_sel,
  output logic          o_mem_we,
  input  logic [DW-1:0] i_mem_data,
  input  logic          i_mem_fin,
  input  logic          i_mem_busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [0:0]    state;
  logic          owner;
  logic          last_grant;
  logic [CW-1:0] wdog;

  logic          pending0, pending1;
  logic [AW-1:0] hold0_addr, hold1_addr;
  logic [DW-1:0] hold0_data, hold1_data;
  logic [2:0]    hold0_sel, hold1_sel;
  logic          hold0_we, hold1_we;

  logic issue, grant1, done_fin, done_to, done;

  assign m0_o_busy = pending0;
  assign m1_o_busy = pending1;

  // Grant decision and completion detection; on a tie the port that was not granted last wins, and a real fin beats the watchdog
  always_comb begin
    issue    = (state == IDLE) && (pending0 || pending1) && !i_mem_busy;
    grant1   = pending1 && (!pending0 || (last_grant == 1'b0));
    done_fin = (state == WAIT) && i_mem_fin;
    done_to  = (state == WAIT) && !i_mem_fin && (TIMEOUT > 0) && (wdog == CW'(TIMEOUT - 1));
    done     = done_fin || done_to;
  end

  // Port 0 request capture; a new exec is ignored while a request is already pending
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pending0   <= 1'b0;
      hold0_addr <= '0;
      hold0_data <= '0;
      hold0_sel  <= '0;
      hold0_we   <= 1'b0;
    end else if (m0_i_exec && !pending0) begin
      pending0   <= 1'b1;
      hold0_addr <= m0_i_addr;
      hold0_data <= m0_i_data;
      hold0_sel  <= m0_i_sel;
      hold0_we   <= m0_i_we;
    end else if (done && (owner == 1'b0)) begin
      pending0 <= 1'b0;
    end
  end

  // Port 1 request capture, mirror of port 0
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pending1   <= 1'b0;
      hold1_addr <= '0;
      hold1_data <= '0;
      hold1_sel  <= '0;
      hold1_we   <= 1'b0;
    end else if (m1_i_exec && !pending1) begin
      pending1   <= 1'b1;
      hold1_addr <= m1_i_addr;
      hold1_data <= m1_i_data;
      hold1_sel  <= m1_i_sel;
      hold1_we   <= m1_i_we;
    end else if (done && (owner == 1'b1)) begin
      pending1 <= 1'b0;
    end
  end

  // Completion routing: only the owner sees fin/data; a timeout returns zero data with err
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      m0_o_fin  <= 1'b0;
      m0_o_err  <= 1'b0;
      m0_o_data <= '0;
      m1_o_fin  <= 1'b0;
      m1_o_err  <= 1'b0;
      m1_o_data <= '0;
    end else begin
      m0_o_fin <= done && (owner == 1'b0);
      m0_o_err <= done_to && (owner == 1'b0);
      m1_o_fin <= done && (owner == 1'b1);
      m1_o_err <= done_to && (owner == 1'b1);
      if (done && (owner == 1'b0)) m0_o_data <= done_fin ? i_mem_data : '0;
      if (done && (owner == 1'b1)) m1_o_data <= done_fin ? i_mem_data : '0;
    end
  end

  // Issue FSM: load mem outputs from the winner, hold them through WAIT, run the watchdog
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wdog       <= '0;
      o_mem_exec <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_sel  <= '0;
      o_mem_we   <= 1'b0;
    end else begin
      o_mem_exec <= issue;
      if (state == IDLE) begin
        if (issue) begin
          o_mem_addr <= grant1 ? hold1_addr : hold0_addr;
          o_mem_data <= grant1 ? hold1_data : hold0_data;
          o_mem_sel  <= grant1 ? hold1_sel  : hold0_sel;
          o_mem_we   <= grant1 ? hold1_we   : hold0_we;
          owner      <= grant1;
          last_grant <= grant1;
          wdog       <= '0;
          state      <= WAIT;
        end
      end else begin
        if (done) begin
          wdog  <= '0;
          state <= IDLE;
        end else begin
          wdog <= wdog + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8): single read, round-robin ties,
// mem busy stall, watchdog timeout, exec while pending and async reset.
module tb_mem_arbiter;

  logic        i_clk;
  logic        i_reset;
  logic        m0_i_exec, m1_i_exec;
  logic [31:0] m0_i_addr, m1_i_addr, m0_i_data, m1_i_data;
  logic [2:0]  m0_i_sel, m1_i_sel;
  logic        m0_i_we, m1_i_we;
  logic [31:0] m0_o_data, m1_o_data;
  logic        m0_o_fin, m0_o_err, m0_o_busy;
  logic        m1_o_fin, m1_o_err, m1_o_busy;
  logic        o_mem_exec, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_data;
  logic [2:0]  o_mem_sel;
  logic [31:0] i_mem_data;
  logic        i_mem_fin, i_mem_busy;

  int checks;
  int errors;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .m0_i_exec(m0_i_exec), .m0_i_addr(m0_i_addr), .m0_i_data(m0_i_data),
    .m0_i_sel(m0_i_sel), .m0_i_we(m0_i_we),
    .m0_o_data(m0_o_data), .m0_o_fin(m0_o_fin), .m0_o_err(m0_o_err), .m0_o_busy(m0_o_busy),
    .m1_i_exec(m1_i_exec), .m1_i_addr(m1_i_addr), .m1_i_data(m1_i_data),
    .m1_i_sel(m1_i_sel), .m1_i_we(m1_i_we),
    .m1_o_data(m1_o_data), .m1_o_fin(m1_o_fin), .m1_o_err(m1_o_err), .m1_o_busy(m1_o_busy),
    .o_mem_exec(o_mem_exec), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_sel(o_mem_sel), .o_mem_we(o_mem_we),
    .i_mem_data(i_mem_data), .i_mem_fin(i_mem_fin), .i_mem_busy(i_mem_busy)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge
  task tick;
    @(posedge i_clk);
    #1;
  endtask

  // Tick until o_mem_exec is seen or the budget runs out
  task wait_exec(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (o_mem_exec === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Assert reset between edges and release it between later edges
  task pulse_reset;
    #2 i_reset = 1'b0;
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    tick();
  endtask

  task test_reset;
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if ({m0_o_fin, m0_o_err, m0_o_busy, m1_o_fin, m1_o_err, m1_o_busy, o_mem_exec, o_mem_we} !== 8'h00 ||
        o_mem_addr !== 32'h0 || o_mem_data !== 32'h0 || m0_o_data !== 32'h0 || m1_o_data !== 32'h0) begin
      $display("[TB] FAIL reset_outputs: got addr=%h data=%h exec=%b, expected all zero", o_mem_addr, o_mem_data, o_mem_exec);
      errors++;
    end
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    tick();
  endtask

  task test_single_read;
    bit seen;
    m0_i_exec = 1'b1; m0_i_addr = 32'h100; m0_i_we = 1'b0; m0_i_sel = 3'd2;
    tick();
    m0_i_exec = 1'b0;
    checks++;
    if (m0_o_busy !== 1'b1 || o_mem_exec !== 1'b0) begin
      $display("[TB] FAIL single_k1: got busy=%b exec=%b, expected busy=1 exec=0", m0_o_busy, o_mem_exec);
      errors++;
    end
    tick();
    checks++;
    if (o_mem_exec !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0 || o_mem_sel !== 3'd2) begin
      $display("[TB] FAIL single_issue: got exec=%b addr=%h we=%b sel=%0d, expected 1 100 0 2", o_mem_exec, o_mem_addr, o_mem_we, o_mem_sel);
      errors++;
    end
    tick();
    checks++;
    if (o_mem_exec !== 1'b0 || o_mem_addr !== 32'h100 || m0_o_busy !== 1'b1) begin
      $display("[TB] FAIL single_exec_pulse: got exec=%b addr=%h busy=%b, expected 0 100 1", o_mem_exec, o_mem_addr, m0_o_busy);
      errors++;
    end
    tick();
    i_mem_fin = 1'b1; i_mem_data = 32'hDEADBEEF;
    tick();
    i_mem_fin = 1'b0;
    checks++;
    if (m0_o_fin !== 1'b1 || m0_o_data !== 32'hDEADBEEF || m0_o_err !== 1'b0 || m0_o_busy !== 1'b0) begin
      $display("[TB] FAIL single_fin: got fin=%b data=%h err=%b busy=%b, expected 1 deadbeef 0 0", m0_o_fin, m0_o_data, m0_o_err, m0_o_busy);
      errors++;
    end
    checks++;
    if (m1_o_fin !== 1'b0 || m1_o_data !== 32'h0 || m1_o_busy !== 1'b0) begin
      $display("[TB] FAIL single_m1_untouched: got fin=%b data=%h busy=%b, expected 0 0 0", m1_o_fin, m1_o_data, m1_o_busy);
      errors++;
    end
    tick();
    checks++;
    if (m0_o_fin !== 1'b0) begin
      $display("[TB] FAIL single_fin_pulse: got fin=%b, expected 0", m0_o_fin);
      errors++;
    end
    seen = 1'b0;
  endtask

  task test_tie_rounds;
    bit seen;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      m0_i_exec = 1'b1; m0_i_addr = 32'h200; m0_i_data = 32'h11; m0_i_we = 1'b1;
      m1_i_exec = 1'b1; m1_i_addr = 32'h300; m1_i_data = 32'h22; m1_i_we = 1'b1;
      tick();
      m0_i_exec = 1'b0; m1_i_exec = 1'b0;
      tick();
      for (int g = 0; g < 2; g++) begin
        exp_addr = (g == 0) ? 32'h200 : 32'h300;
        exp_data = (g == 0) ? 32'h11 : 32'h22;
        checks++;
        if (o_mem_exec !== 1'b1 || o_mem_addr !== exp_addr || o_mem_data !== exp_data || o_mem_we !== 1'b1) begin
          $display("[TB] FAIL tie_r%0d_g%0d: got exec=%b addr=%h data=%h, expected 1 %h %h", r, g, o_mem_exec, o_mem_addr, o_mem_data, exp_addr, exp_data);
          errors++;
        end
        tick();
        i_mem_fin = 1'b1; i_mem_data = (g == 0) ? 32'hAAAA0000 : 32'hBBBB0000;
        tick();
        i_mem_fin = 1'b0;
        checks++;
        if (m0_o_fin !== (g == 0) || m1_o_fin !== (g == 1) || m0_o_busy !== 1'b0 || m1_o_busy !== (g == 0)) begin
          $display("[TB] FAIL tie_fin_r%0d_g%0d: got fin0=%b fin1=%b busy0=%b busy1=%b", r, g, m0_o_fin, m1_o_fin, m0_o_busy, m1_o_busy);
          errors++;
        end
        tick();
      end
    end
    checks++;
    if (m0_o_data !== 32'hAAAA0000 || m1_o_data !== 32'hBBBB0000) begin
      $display("[TB] FAIL tie_data: got d0=%h d1=%h, expected aaaa0000 bbbb0000", m0_o_data, m1_o_data);
      errors++;
    end
    seen = 1'b0;
  endtask

  task test_mem_busy;
    int early;
    early = 0;
    i_mem_busy = 1'b1;
    m1_i_exec = 1'b1; m1_i_addr = 32'h340; m1_i_we = 1'b0;
    tick();
    m1_i_exec = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (o_mem_exec !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      $display("[TB] FAIL busy_stall: got %0d exec cycles while mem busy, expected 0", early);
      errors++;
    end
    i_mem_busy = 1'b0;
    tick();
    checks++;
    if (o_mem_exec !== 1'b1 || o_mem_addr !== 32'h340) begin
      $display("[TB] FAIL busy_release: got exec=%b addr=%h, expected 1 340", o_mem_exec, o_mem_addr);
      errors++;
    end
    i_mem_fin = 1'b1; i_mem_data = 32'h0BADF00D;
    tick();
    i_mem_fin = 1'b0;
    checks++;
    if (m1_o_fin !== 1'b1 || m1_o_data !== 32'h0BADF00D || m0_o_fin !== 1'b0) begin
      $display("[TB] FAIL busy_fin: got fin1=%b data=%h fin0=%b, expected 1 0badf00d 0", m1_o_fin, m1_o_data, m0_o_fin);
      errors++;
    end
    tick();
  endtask

  task test_timeout;
    bit seen;
    m0_i_exec = 1'b1; m0_i_addr = 32'h500; m0_i_we = 1'b0;
    tick();
    m0_i_exec = 1'b0;
    wait_exec(10, seen);
    checks++;
    if (!seen) begin
      $display("[TB] FAIL timeout_issue: got no exec within 10 cycles, expected exec");
      errors++;
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (m0_o_fin !== 1'b0 || m0_o_err !== 1'b0) begin
      $display("[TB] FAIL timeout_early: got fin=%b err=%b at 7 cycles, expected 0 0", m0_o_fin, m0_o_err);
      errors++;
    end
    tick();
    checks++;
    if (m0_o_fin !== 1'b1 || m0_o_err !== 1'b1 || m0_o_data !== 32'h0 || m0_o_busy !== 1'b0) begin
      $display("[TB] FAIL timeout_fire: got fin=%b err=%b data=%h busy=%b, expected 1 1 0 0", m0_o_fin, m0_o_err, m0_o_data, m0_o_busy);
      errors++;
    end
    tick();
    checks++;
    if (m0_o_err !== 1'b0) begin
      $display("[TB] FAIL timeout_err_pulse: got err=%b, expected 0", m0_o_err);
      errors++;
    end
    m1_i_exec = 1'b1; m1_i_addr = 32'h600;
    tick();
    m1_i_exec = 1'b0;
    wait_exec(10, seen);
    tick();
    i_mem_fin = 1'b1; i_mem_data = 32'h12345678;
    tick();
    i_mem_fin = 1'b0;
    checks++;
    if (!seen || m1_o_fin !== 1'b1 || m1_o_err !== 1'b0 || m1_o_data !== 32'h12345678) begin
      $display("[TB] FAIL timeout_then_m1: got seen=%b fin=%b err=%b data=%h, expected 1 1 0 12345678", seen, m1_o_fin, m1_o_err, m1_o_data);
      errors++;
    end
    tick();
    m0_i_exec = 1'b1; m0_i_addr = 32'h540;
    tick();
    m0_i_exec = 1'b0;
    wait_exec(10, seen);
    for (int i = 0; i < 7; i++) tick();
    i_mem_fin = 1'b1; i_mem_data = 32'h0000CAFE;
    tick();
    i_mem_fin = 1'b0;
    checks++;
    if (!seen || m0_o_fin !== 1'b1 || m0_o_err !== 1'b0 || m0_o_data !== 32'h0000CAFE) begin
      $display("[TB] FAIL timeout_fin_wins: got seen=%b fin=%b err=%b data=%h, expected 1 1 0 0000cafe", seen, m0_o_fin, m0_o_err, m0_o_data);
      errors++;
    end
    tick();
  endtask

  task test_exec_while_busy;
    int fins;
    int execs;
    fins = 0; execs = 0;
    m0_i_exec = 1'b1; m0_i_addr = 32'h100;
    tick();
    m0_i_addr = 32'h400;
    tick();
    m0_i_exec = 1'b0;
    checks++;
    if (o_mem_exec !== 1'b1 || o_mem_addr !== 32'h100) begin
      $display("[TB] FAIL ewb_issue: got exec=%b addr=%h, expected 1 100", o_mem_exec, o_mem_addr);
      errors++;
    end
    tick();
    i_mem_fin = 1'b1; i_mem_data = 32'h77;
    m0_i_exec = 1'b1; m0_i_addr = 32'h700;
    tick();
    i_mem_fin = 1'b0; m0_i_exec = 1'b0;
    if (m0_o_fin === 1'b1) fins++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m0_o_fin === 1'b1) fins++;
      if (o_mem_exec === 1'b1) execs++;
    end
    checks++;
    if (fins != 1 || execs != 0 || m0_o_busy !== 1'b0) begin
      $display("[TB] FAIL ewb_single: got fins=%0d execs=%0d busy=%b, expected 1 0 0", fins, execs, m0_o_busy);
      errors++;
    end
  endtask

  task test_reset_mid_wait;
    bit seen;
    int fins;
    fins = 0;
    m0_i_exec = 1'b1; m0_i_addr = 32'h800; m0_i_data = 32'h99; m0_i_we = 1'b1;
    tick();
    m0_i_exec = 1'b0;
    wait_exec(10, seen);
    tick();
    #2 i_reset = 1'b0;
    #1;
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_data !== 32'h0 || o_mem_we !== 1'b0 || m0_o_busy !== 1'b0 ||
        m0_o_data !== 32'h0 || m1_o_data !== 32'h0) begin
      $display("[TB] FAIL async_reset: got addr=%h data=%h we=%b busy=%b, expected all zero", o_mem_addr, o_mem_data, o_mem_we, m0_o_busy);
      errors++;
    end
    @(posedge i_clk);
    #3 i_reset = 1'b1;
    i_mem_fin = 1'b1;
    tick();
    i_mem_fin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m0_o_fin === 1'b1 || m1_o_fin === 1'b1 || o_mem_exec === 1'b1) fins++;
      tick();
    end
    checks++;
    if (fins != 0 || !seen) begin
      $display("[TB] FAIL reset_no_fin: got %0d fin/exec cycles seen=%b, expected 0 1", fins, seen);
      errors++;
    end
    m1_i_exec = 1'b1; m1_i_addr = 32'h900; m1_i_we = 1'b0;
    tick();
    m1_i_exec = 1'b0;
    tick();
    checks++;
    if (o_mem_exec !== 1'b1 || o_mem_addr !== 32'h900) begin
      $display("[TB] FAIL reset_fresh_issue: got exec=%b addr=%h, expected 1 900", o_mem_exec, o_mem_addr);
      errors++;
    end
    i_mem_fin = 1'b1; i_mem_data = 32'h5A5A5A5A;
    tick();
    i_mem_fin = 1'b0;
    checks++;
    if (m1_o_fin !== 1'b1 || m1_o_data !== 32'h5A5A5A5A) begin
      $display("[TB] FAIL reset_fresh_fin: got fin=%b data=%h, expected 1 5a5a5a5a", m1_o_fin, m1_o_data);
      errors++;
    end
    tick();
  endtask

  // Sequence the scenarios and report
  initial begin
    checks = 0; errors = 0;
    i_reset = 1'b1;
    m0_i_exec = 1'b0; m0_i_addr = '0; m0_i_data = '0; m0_i_sel = '0; m0_i_we = 1'b0;
    m1_i_exec = 1'b0; m1_i_addr = '0; m1_i_data = '0; m1_i_sel = '0; m1_i_we = 1'b0;
    i_mem_data = '0; i_mem_fin = 1'b0; i_mem_busy = 1'b0;
    test_reset();
    test_single_read();
    test_tie_rounds();
    test_mem_busy();
    test_timeout();
    test_exec_while_busy();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
